// File: rtl/window_extrema_tracker.sv
// Per-window max/min and rise/fall statistics over WIN_LEN accepted samples, valid/ready on both sides.
// Optional macro TRACKER_ARGMAX_EN adds out_max_idx, the index of the first occurrence of the maximum.
module window_extrema_tracker #(
    parameter int WIDTH   = 4,
    parameter int WIN_LEN = 8,
    parameter int CNT_W   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_max,
    output logic [WIDTH-1:0] out_min,
    output logic [CNT_W-1:0] out_rise,
    output logic [CNT_W-1:0] out_fall
`ifdef TRACKER_ARGMAX_EN
    ,
    output logic [CNT_W-1:0] out_max_idx
`endif
);

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t           state;
    logic [CNT_W-1:0] idx;
    logic [CNT_W-1:0] rise_cnt;
    logic [CNT_W-1:0] fall_cnt;
    logic [WIDTH-1:0] run_max;
    logic [WIDTH-1:0] run_min;
    logic [WIDTH-1:0] prev;

    logic             accept;
    logic             first;
    logic             last;
    logic [WIDTH-1:0] nxt_max;
    logic [WIDTH-1:0] nxt_min;
    logic [CNT_W-1:0] nxt_rise;
    logic [CNT_W-1:0] nxt_fall;

    assign in_ready = (state == ACCUM);
    assign accept   = in_valid && in_ready;
    assign first    = (idx == '0);
    assign last     = (idx == CNT_W'(WIN_LEN - 1));

    // Running statistics including the sample on in_data; only meaningful when it is accepted.
    always_comb begin
        nxt_max  = run_max;
        nxt_min  = run_min;
        nxt_rise = rise_cnt;
        nxt_fall = fall_cnt;
        if (first) begin
            nxt_max  = in_data;
            nxt_min  = in_data;
            nxt_rise = '0;
            nxt_fall = '0;
        end else begin
            if (in_data > run_max) nxt_max = in_data;
            if (in_data < run_min) nxt_min = in_data;
            if (in_data > prev)    nxt_rise = rise_cnt + CNT_W'(1);
            if (in_data < prev)    nxt_fall = fall_cnt + CNT_W'(1);
        end
    end

`ifdef TRACKER_ARGMAX_EN
    logic [CNT_W-1:0] run_max_idx;
    logic [CNT_W-1:0] nxt_max_idx;

    // Strict compare so ties keep the earliest index.
    always_comb begin
        nxt_max_idx = run_max_idx;
        if (first)
            nxt_max_idx = '0;
        else if (in_data > run_max)
            nxt_max_idx = idx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_max_idx <= '0;
            out_max_idx <= '0;
        end else if (clear) begin
            run_max_idx <= '0;
            out_max_idx <= '0;
        end else if (accept) begin
            run_max_idx <= nxt_max_idx;
            if (last) out_max_idx <= nxt_max_idx;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACCUM;
            out_valid <= 1'b0;
            idx       <= '0;
            rise_cnt  <= '0;
            fall_cnt  <= '0;
            run_max   <= '0;
            run_min   <= '0;
            prev      <= '0;
            out_max   <= '0;
            out_min   <= '0;
            out_rise  <= '0;
            out_fall  <= '0;
        end else if (clear) begin
            state     <= ACCUM;
            out_valid <= 1'b0;
            idx       <= '0;
            rise_cnt  <= '0;
            fall_cnt  <= '0;
            run_max   <= '0;
            run_min   <= '0;
            prev      <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        run_max  <= nxt_max;
                        run_min  <= nxt_min;
                        rise_cnt <= nxt_rise;
                        fall_cnt <= nxt_fall;
                        prev     <= in_data;
                        idx      <= idx + CNT_W'(1);
                        if (last) begin
                            out_max   <= nxt_max;
                            out_min   <= nxt_min;
                            out_rise  <= nxt_rise;
                            out_fall  <= nxt_fall;
                            out_valid <= 1'b1;
                            state     <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    // Results stay on out_* after handoff until the next window end.
                    if (out_ready) begin
                        state     <= ACCUM;
                        out_valid <= 1'b0;
                        idx       <= '0;
                        rise_cnt  <= '0;
                        fall_cnt  <= '0;
                    end
                end
                default: begin
                    state     <= ACCUM;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_window_extrema_tracker.sv
// Self-checking bench for window_extrema_tracker: directed windows plus randomized traffic
// checked against a queue-based window model.
module tb_window_extrema_tracker;

    localparam int WIDTH   = 4;
    localparam int WIN_LEN = 4;
    localparam int CNT_W   = 2;

    logic             clk;
    logic             rst_n;
    logic             clear;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_max;
    logic [WIDTH-1:0] out_min;
    logic [CNT_W-1:0] out_rise;
    logic [CNT_W-1:0] out_fall;
`ifdef TRACKER_ARGMAX_EN
    logic [CNT_W-1:0] out_max_idx;
`endif

    window_extrema_tracker #(.WIDTH(WIDTH), .WIN_LEN(WIN_LEN), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_max   (out_max),
        .out_min   (out_min),
        .out_rise  (out_rise),
        .out_fall  (out_fall)
`ifdef TRACKER_ARGMAX_EN
        ,
        .out_max_idx (out_max_idx)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors;
    int miscompares;

    // Reference model: accepted samples of the open window, and the last reported result.
    int win_q[$];
    bit exp_hold;
    bit out_known;
    int exp_max, exp_min, exp_rise, exp_fall, exp_idx;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        win_q.delete();
        exp_hold  = 1'b0;
        out_known = 1'b1;
        exp_max = 0; exp_min = 0; exp_rise = 0; exp_fall = 0; exp_idx = 0;
    endtask

    task automatic closeWindow();
        exp_max = win_q[0]; exp_min = win_q[0];
        exp_rise = 0; exp_fall = 0; exp_idx = 0;
        for (int i = 1; i < win_q.size(); i++) begin
            if (win_q[i] > exp_max) begin
                exp_max = win_q[i];
                exp_idx = i;
            end
            if (win_q[i] < exp_min) exp_min = win_q[i];
            if (win_q[i] > win_q[i-1]) exp_rise++;
            if (win_q[i] < win_q[i-1]) exp_fall++;
        end
        win_q.delete();
        exp_hold  = 1'b1;
        out_known = 1'b1;
    endtask

    task automatic checkState();
        checkOutput("in_ready", int'(in_ready), int'(!exp_hold));
        checkOutput("out_valid", int'(out_valid), int'(exp_hold));
        if (out_known) begin
            checkOutput("out_max", int'(out_max), exp_max);
            checkOutput("out_min", int'(out_min), exp_min);
            checkOutput("out_rise", int'(out_rise), exp_rise);
            checkOutput("out_fall", int'(out_fall), exp_fall);
`ifdef TRACKER_ARGMAX_EN
            checkOutput("out_max_idx", int'(out_max_idx), exp_idx);
`endif
        end
    endtask

    // One cycle: drive inputs after a falling edge, check, advance the model, wait for the next falling edge.
    task automatic applyStimulus(input bit v, input int d, input bit ordy, input bit clr);
        in_valid  = v;
        in_data   = WIDTH'(d);
        out_ready = ordy;
        clear     = clr;
        checkState();
        if (clr) begin
            win_q.delete();
            exp_hold  = 1'b0;
            out_known = 1'b0;
        end else if (exp_hold) begin
            if (ordy) exp_hold = 1'b0;
        end else if (v) begin
            win_q.push_back(d);
            if (win_q.size() == WIN_LEN) closeWindow();
        end
        @(negedge clk);
    endtask

    task automatic feedWindow(input int a, input int b, input int c, input int e);
        applyStimulus(1, a, 1, 0);
        applyStimulus(1, b, 1, 0);
        applyStimulus(1, c, 1, 0);
        applyStimulus(1, e, 1, 0);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        modelReset();

        // Reset held for three cycles with a sample offered: nothing may be captured.
        in_valid = 1'b1; in_data = 4'd9;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkState();
        end
        rst_n = 1'b1;
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 1, 0);

        feedWindow(3, 9, 2, 9);
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 1, 0);

        feedWindow(5, 5, 5, 5);
        applyStimulus(0, 0, 1, 0);

        // Back-pressured result while upstream keeps offering 7s.
        applyStimulus(1, 1, 0, 0);
        applyStimulus(1, 2, 0, 0);
        applyStimulus(1, 3, 0, 0);
        applyStimulus(1, 4, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 7, 0, 0);
        applyStimulus(1, 7, 1, 0);
        feedWindow(7, 7, 6, 8);
        applyStimulus(0, 0, 1, 0);

        // Clear mid-window discards the partial window and the sample offered with it.
        applyStimulus(1, 8, 1, 0);
        applyStimulus(1, 1, 1, 0);
        applyStimulus(1, 6, 1, 1);
        feedWindow(0, 15, 15, 0);
        applyStimulus(0, 0, 1, 0);

        // Clear while a result is held drops it.
        feedWindow(4, 2, 6, 1);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 1, 0);

        // Asynchronous reset while in HOLD.
        applyStimulus(1, 2, 0, 0);
        applyStimulus(1, 12, 0, 0);
        applyStimulus(1, 5, 0, 0);
        applyStimulus(1, 13, 0, 0);
        checkState();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput("async_out_valid", int'(out_valid), 0);
        checkOutput("async_in_ready", int'(in_ready), 1);
        @(negedge clk);
        checkState();
        rst_n = 1'b1;
        feedWindow(2, 2, 3, 1);
        applyStimulus(0, 0, 1, 0);

        // Randomized traffic with back-pressure and occasional clears.
        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, int'($urandom_range(0, 15)),
                          $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0);
        end
        applyStimulus(0, 0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/window_extrema_tracker.md
Name: window_extrema_tracker

Overview:
Streaming stage that consumes a sequence of unsigned WIDTH-bit samples and, over fixed windows of WIN_LEN accepted samples, reports the window maximum, minimum, and rise/fall counts between consecutive samples. It sits downstream of the combinational magnitude-comparison logic and turns per-pair relations into per-window statistics. Valid/ready handshakes are used on both input and output.

Parameters:
WIDTH, 4, sample width in bits; all comparisons are unsigned.
WIN_LEN, 8, samples per window; legal range 2..2^CNT_W.
CNT_W, 3, width of the sample index and counters; requires 2^CNT_W >= WIN_LEN.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
clear  input  1  synchronous window abort.
in_valid  input  1  in_data is valid.
in_ready  output  1  block can accept a sample.
in_data  input  WIDTH  sample.
out_valid  output  1  window result is valid.
out_ready  input  1  downstream accepts the result.
out_max  output  WIDTH  largest sample in the window.
out_min  output  WIDTH  smallest sample in the window.
out_rise  output  CNT_W  count of samples strictly greater than the previous sample.
out_fall  output  CNT_W  count of samples strictly less than the previous sample.

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous and active-low. While rst_n is low:
  - state is ACCUM;
  - out_valid, out_max, out_min, out_rise, out_fall and the internal index, counters and previous-sample register are all 0;
  - in_ready reads 1, but no sample is captured.
- FSM states: ACCUM and HOLD.
  - in_ready = (state == ACCUM), decoded combinationally from state.
  - out_valid = (state == HOLD), registered.
- Accept rule: a sample is accepted when in_valid && in_ready at a rising edge.
- ACCUM, index 0 (first sample of a window): running max = min = sample; no rise or fall update; prev = sample.
- ACCUM, index k > 0:
  - max updates only if sample > max; min updates only if sample < min. Ties keep the existing value.
  - rise increments if sample > prev; fall increments if sample < prev. Equal samples change neither.
  - prev = sample.
- Window end: acceptance of the sample at index WIN_LEN-1 loads out_* with the final values, including that sample, and moves to HOLD. out_valid is high on the next cycle, so latency is 1 cycle after the last accept.
- HOLD:
  - out_* are stable and in_ready = 0; in_valid is ignored (not accepted, not lost from the upstream's view).
  - When out_valid && out_ready: go to ACCUM and clear the index and counters. out_* keep their values until the next window end.
  - Throughput: at least one idle input cycle per window, in the handoff cycle.
- clear (synchronous, highest priority after reset):
  - state goes to ACCUM; index, counters and running max/min return to 0; out_valid drops next cycle.
  - A sample presented in the same cycle as clear is discarded.
  - A HOLD result not yet taken is dropped.
- Counter width: index wraps only via the window end; rise and fall are at most WIN_LEN-1, so they never overflow.
- Reset mid-window or in HOLD: all progress is discarded immediately (asynchronous), and out_valid falls without waiting for a clock.

Optional Feature:
Macro: TRACKER_ARGMAX_EN.
- Defined: adds output port out_max_idx [CNT_W-1:0], the 0-based index within the window of the first occurrence of the maximum (ties keep the earliest index). It resets to 0, loads at window end alongside out_max, and is cleared by clear.
- Not defined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
1. Assert rst_n=0 for 3 cycles -> out_valid=0, out_max=out_min=out_rise=out_fall=0, in_ready=1. Release -> no state change until a sample is accepted.
2. WIDTH=4, WIN_LEN=4, out_ready=1; feed 3,9,2,9 on consecutive cycles -> out_valid=1 for exactly one cycle, one cycle after the 4th accept, with max=9, min=2, rise=2, fall=1 (out_max_idx=1 when TRACKER_ARGMAX_EN is defined). in_ready=0 during that cycle.
3. Feed 5,5,5,5 -> max=5, min=5, rise=0, fall=0, idx=0.
4. Window 1,2,3,4 with out_ready=0 for 3 cycles after out_valid -> out_valid and out_* stay stable (max=4, min=1, rise=3), in_ready=0, and samples 7,7 presented meanwhile are not consumed. Raise out_ready -> next window starts clean with 7 as index 0.
5. Accept 8,1, then pulse clear for one cycle while in_valid=1 with data 6 -> 6 is discarded. Then feed 0,15,15,0 -> max=15, min=0, rise=1, fall=1, idx=1.
6. Drive rst_n low asynchronously while in HOLD (mid-cycle) -> out_valid falls before the next edge. After release, a full window of 2,2,3,1 yields max=3, min=1, rise=1, fall=1.
